fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the control unit. Holds the 64-bit PC and requests a 32-bit instruction word from instruction memory with a req/ready handshake. Latches the word into an instruction register for the control unit, then waits for the control unit's advance pulse. On advance, it applies the control unit's PS/k outputs to compute the next PC.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
TIMEOUT_CYCLES, 16, max FETCH wait cycles before fault (used only with FETCH_TIMEOUT_EN)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
ps  input  2  PC select from control word: 00 hold, 01 PC+4, 10 load pc_in, 11 PC+(k<<2)
k  input  64  sign-extended branch offset, in words, from control unit
pc_in  input  64  register-sourced branch target (BR)
advance  input  1  single-cycle pulse from control unit: current instruction retired, apply ps
mem_req  output  1  instruction-memory read request
mem_addr  output  64  fetch address (= pc)
mem_data  input  32  instruction word from memory
mem_ready  input  1  mem_data valid this cycle
instruction  output  32  instruction register to control unit
instr_valid  output  1  instruction holds a fetched word for the current pc
pc  output  64  address of current instruction
pc_plus4  output  64  pc+4, for BL link write
fetch_fault  output  1  sticky timeout fault (FETCH_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset (sync, high) state: pc=RESET_PC; instruction=32'h0; instr_valid=0; mem_req=0; fetch_fault=0; state=FETCH on the first cycle after reset deasserts. Reset asserted mid-fetch abandons the request, and mem_req is 0 the next cycle.
- States:
  - FETCH: mem_req=1, mem_addr=pc, both held stable until mem_ready. On mem_ready: instruction<=mem_data, instr_valid<=1, go to HOLD. Minimum fetch latency is 1 cycle (ready in the first req cycle).
  - HOLD: mem_req=0, instruction stable. On advance, next-PC is computed from ps:
    - 00: pc unchanged, stay in HOLD, instr_valid stays 1 (halt/stall, no refetch).
    - 01: pc<=pc+4.
    - 10: pc<=pc_in.
    - 11: pc<=pc+(k<<2).
    - For 01/10/11: instr_valid<=0, go to FETCH next cycle.
- Arithmetic: all 64-bit, modulo 2^64. Wrap-around is silent (FFFF_FFFF_FFFF_FFFC+4 -> 0). k<<2 discards the top 2 bits. No alignment check is made. pc_plus4 = pc+4, combinational.
- advance in FETCH is ignored and not queued. mem_ready while mem_req=0 is ignored. ps/k/pc_in are sampled only on the advance cycle.
- advance and reset in the same cycle: reset wins.
- Throughput: at 1-cycle memory, one instruction every 2 cycles plus control-unit hold time.

Optional Feature:
FETCH_TIMEOUT_EN:
- Defined:
  - A counter runs in FETCH, clearing on entry.
  - If mem_ready is absent for TIMEOUT_CYCLES consecutive req cycles, fetch_fault<=1 and the block enters FAULT (mem_req=0, instr_valid=0, advance ignored).
  - Only reset leaves FAULT.
- Undefined: no counter, no FAULT state, fetch_fault tied 0, and FETCH waits indefinitely.

Decomposition:
- Shared package:
  - PS encoding constants PS_HOLD=2'b00, PS_INC=2'b01, PS_REG=2'b10, PS_REL=2'b11.
  - Fetch state typedef (FETCH, HOLD, FAULT).
  - Width constants PC_W=64, INSTR_W=32.
  - The control unit imports the same PS constants.
- One natural sub-module, pc_next: combinational next-PC mux/adders (pc, ps, k, pc_in -> next_pc). The FSM and registers stay in fetch_unit.

Test Plan:
- Reset then mem_ready same cycle as first req, mem_data=32'h91000421 -> mem_addr=0 and mem_req=1 in cycle 1; instruction=32'h91000421, instr_valid=1 in cycle 2; mem_req=0.
- In HOLD at pc=0x100, advance with ps=01 -> pc=0x104 and mem_req=1 next cycle. Advance with ps=11, k=-2 (64'hFFFF...FFFE) at pc=0x104 -> pc=0xFC.
- In HOLD, ps=10, pc_in=0x2000 -> mem_addr=0x2000. Then ps=00 advance -> pc stays 0x2000, no mem_req, instr_valid stays 1.
- Memory stalls 5 cycles -> mem_req and mem_addr stable all 5 cycles. advance pulsed during the stall is ignored and pc is unchanged after capture.
- pc=64'hFFFF_FFFF_FFFF_FFFC, ps=01 -> pc=0. Reset asserted mid-FETCH -> next cycle mem_req=0, instr_valid=0, pc=RESET_PC.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no mem_ready -> fetch_fault=1 after 16 req cycles, mem_req=0. advance is ignored; reset clears fetch_fault.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: PC-select encoding (also used by the control unit),
// fetch state encoding and datapath widths.
package fetch_unit_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REG  = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH = 2'd0;
  localparam fetch_state_t ST_HOLD  = 2'd1;
  localparam fetch_state_t ST_FAULT = 2'd2;

  // Any select other than HOLD moves the PC and forces a refetch.
  function automatic logic ps_redirects(input logic [1:0] ps);
    return ps != PS_HOLD;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: hold, +4, register target, or word-relative branch.
module pc_next
  import fetch_unit_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [1:0]      ps,
  input  logic [PC_W-1:0] k,
  input  logic [PC_W-1:0] pc_in,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    case (ps)
      PS_INC:  next_pc = pc + 64'd4;
      PS_REG:  next_pc = pc_in;
      PS_REL:  next_pc = pc + (k << 2);  // top two offset bits fall off; wraps mod 2^64
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, req/ready fetch into the instruction register,
// PC update on advance. FETCH_TIMEOUT_EN adds a sticky fault when memory never answers.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         ps,
  input  logic [PC_W-1:0]    k,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               advance,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               mem_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus4,
  output logic               fetch_fault
);

  fetch_state_t        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, next_pc;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                in_reset_q;

  pc_next u_pc_next (
    .pc      (pc_q),
    .ps      (ps),
    .k       (k),
    .pc_in   (pc_in),
    .next_pc (next_pc)
  );

  // State is already FETCH while reset is held; in_reset_q keeps the request quiet until release.
  assign mem_req     = (state_q == ST_FETCH) && !in_reset_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 64'd4;
  assign instruction = instr_q;
  assign instr_valid = valid_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    fault_d = fault_q;
`endif
    case (state_q)
      ST_FETCH: begin
        if (mem_req) begin
          if (mem_ready) begin
            instr_d = mem_data;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      ST_HOLD: begin
        if (advance && ps_redirects(ps)) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: ;  // FAULT: only reset leaves
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      in_reset_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
      cnt_q      <= '0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      in_reset_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit, checked against a transaction-level PC/instruction model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  ps;
  logic [63:0] k, pc_in;
  logic        advance;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc, pc_plus4;
  logic        fetch_fault;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] exp_pc;
  logic [31:0] exp_instr;
  bit          need_fetch;

  fetch_unit dut (
    .clock(clock), .reset(reset), .ps(ps), .k(k), .pc_in(pc_in), .advance(advance),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Model: a fetch must present exp_pc, hold it through any stall, then latch the word.
  task automatic fetch_word(input logic [31:0] data, input int stall, input bit poke_adv);
    int w = 0;
    while (!mem_req && w < 20) begin tick(); w++; end
    chk("req_seen", mem_req, 1);
    for (int i = 0; i < stall; i++) begin
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, exp_pc);
      chk("stall_valid", instr_valid, 0);
      if (poke_adv && i == 1) begin advance = 1'b1; ps = PS_INC; end
      tick();
      advance = 1'b0;
    end
    chk("fetch_addr", mem_addr, exp_pc);
    mem_ready = 1'b1;
    mem_data  = data;
    tick();
    mem_ready = 1'b0;
    mem_data  = $urandom;
    exp_instr = data;
    chk("instr", instruction, exp_instr);
    chk("valid", instr_valid, 1);
    chk("req_drop", mem_req, 0);
    chk("pc_after_fetch", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 64'd4);
  endtask

  task automatic do_advance(input logic [1:0] ps_v, input logic [63:0] k_v, input logic [63:0] pcin_v);
    logic [63:0] nxt;
    if (ps_v == 2'b01)      nxt = exp_pc + 64'd4;
    else if (ps_v == 2'b10) nxt = pcin_v;
    else if (ps_v == 2'b11) nxt = exp_pc + k_v * 64'd4;
    else                    nxt = exp_pc;
    ps = ps_v; k = k_v; pc_in = pcin_v; advance = 1'b1;
    tick();
    advance = 1'b0;
    ps = 2'($urandom); k = {$urandom, $urandom}; pc_in = {$urandom, $urandom};
    if (ps_v == 2'b00) begin
      chk("hold_pc", pc, exp_pc);
      chk("hold_valid", instr_valid, 1);
      chk("hold_req", mem_req, 0);
      chk("hold_instr", instruction, exp_instr);
      need_fetch = 1'b0;
    end else begin
      exp_pc = nxt;
      chk("adv_pc", pc, exp_pc);
      chk("adv_valid", instr_valid, 0);
      chk("adv_req", mem_req, 1);
      chk("adv_addr", mem_addr, exp_pc);
      need_fetch = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; ps = 2'b00; k = '0; pc_in = '0; advance = 1'b0;
    mem_data = '0; mem_ready = 1'b0;
    exp_pc = 64'h0; exp_instr = 32'h0; need_fetch = 1'b1;

    // Reset state, then a 1-cycle fetch
    tick(); tick();
    chk("rst_req", mem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_fault", fetch_fault, 0);
    reset = 1'b0;
    tick();
    chk("c1_req", mem_req, 1);
    chk("c1_addr", mem_addr, 64'h0);
    mem_ready = 1'b1; mem_data = 32'h91000421;
    tick();
    mem_ready = 1'b0;
    exp_instr = 32'h91000421;
    chk("c2_instr", instruction, 32'h91000421);
    chk("c2_valid", instr_valid, 1);
    chk("c2_req", mem_req, 0);

    // Directed next-PC cases
    do_advance(PS_REG, '0, 64'h100);
    fetch_word($urandom, 0, 0);
    do_advance(PS_INC, '0, '0);
    chk("pc_104", pc, 64'h104);
    fetch_word($urandom, 1, 0);
    do_advance(PS_REL, 64'hFFFF_FFFF_FFFF_FFFE, '0);
    chk("pc_fc", pc, 64'hFC);
    fetch_word($urandom, 0, 0);
    do_advance(PS_REG, '0, 64'h2000);
    chk("addr_2000", mem_addr, 64'h2000);
    fetch_word($urandom, 0, 0);
    do_advance(PS_HOLD, 64'h5, 64'h9999);
    do_advance(PS_HOLD, 64'h7, 64'h1234);
    chk("pc_2000_held", pc, 64'h2000);
    do_advance(PS_INC, '0, '0);
    fetch_word($urandom, 5, 1);  // 5-cycle stall with an advance pulse that must be ignored

    // Wrap-around
    do_advance(PS_REG, '0, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_word($urandom, 0, 0);
    do_advance(PS_INC, '0, '0);
    chk("pc_wrap", pc, 64'h0);

    // Randomized transactions, including stray mem_ready while idle
    for (int it = 0; it < 30; it++) begin
      logic [63:0] kv;
      int sk;
      if (need_fetch) fetch_word($urandom, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
        mem_ready = 1'b1; mem_data = $urandom;
        tick();
        mem_ready = 1'b0;
        chk("idle_instr", instruction, exp_instr);
        chk("idle_valid", instr_valid, 1);
        chk("idle_req", mem_req, 0);
      end
      sk = int'($urandom_range(0, 200)) - 100;
      kv = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'(sk);
      do_advance(2'($urandom), kv, {$urandom, $urandom});
    end
    if (need_fetch) fetch_word($urandom, 0, 0);

    // Reset wins over a same-cycle advance
    reset = 1'b1; advance = 1'b1; ps = PS_INC;
    tick();
    advance = 1'b0;
    exp_pc = 64'h0;
    chk("rstadv_pc", pc, 64'h0);
    chk("rstadv_valid", instr_valid, 0);
    chk("rstadv_req", mem_req, 0);
    reset = 1'b0;
    tick();
    chk("rstadv_req1", mem_req, 1);
    fetch_word($urandom, 0, 0);

    // Reset mid-fetch abandons the request
    do_advance(PS_REG, '0, 64'h3000);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_req", mem_req, 0);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_pc", pc, 64'h0);
    reset = 1'b0;
    exp_pc = 64'h0;
    tick();
    chk("midrst_req1", mem_req, 1);

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_nofault", fetch_fault, 0);
      chk("to_req", mem_req, 1);
    end
    tick();
    chk("to_fault", fetch_fault, 1);
    chk("to_req0", mem_req, 0);
    chk("to_valid", instr_valid, 0);
    advance = 1'b1; ps = PS_INC;
    tick();
    advance = 1'b0;
    chk("to_adv_pc", pc, 64'h0);
    chk("to_adv_fault", fetch_fault, 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("to_ready_valid", instr_valid, 0);
    chk("to_ready_req", mem_req, 0);
    reset = 1'b1;
    tick();
    chk("to_rst_fault", fetch_fault, 0);
    reset = 1'b0;
    tick();
    chk("to_rst_req", mem_req, 1);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("long_stall_req", mem_req, 1);
    chk("long_stall_fault", fetch_fault, 0);
    chk("long_stall_addr", mem_addr, 64'h0);
    fetch_word(32'hDEAD_BEEF, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
